// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit.
// Contains the opcodes, the FSM state encoding, the immSrc encodings (these must
// match the sign-extender select), the ALU operation codes and the aluOp codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: combinational mapping from aluOp/funct3/funct7b5/op[5] to the
// ALU operation code.
//   aluOp      in  2  operation class from the control FSM
//   funct3     in  3  instruction bits [14:12]
//   funct7b5   in  1  instruction bit 30
//   op5        in  1  opcode bit 5 (1 for R-type, 0 for I-type ALU)
//   aluControl out 3  ALU operation
module alu_dec
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type has a sub; addi with imm bit 30 set must still add.
          3'b000:  aluControl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/unidad_control_mc.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/memory/
// writeback, plus immSrc and ALU decoding.
//   clk, rst                     clock, synchronous active-high reset
//   op, funct3, funct7b5         instruction fields
//   zero                         ALU zero flag (used only in BEQ)
//   immSrc                       extender select
//   aluSrcA, aluSrcB, resultSrc  datapath mux selects
//   aluControl                   ALU operation
//   adrSrc                       memory address select
//   irWrite, pcWrite, regWrite, memWrite  write enables (all 0 during reset)
module unidad_control_mc
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [2:0] aluControl,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWrite
);

  state_t     state_q, state_d;
  state_t     out_state;
  logic [1:0] alu_op;
  logic       pc_update, branch, ir_wr, reg_wr, mem_wr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // During reset the outputs present the FETCH decode with every write
  // enable masked, so a write pending in the current state never fires.
  assign out_state = rst ? S_FETCH : state_q;

  always_comb begin
    adrSrc    = 1'b0;
    ir_wr     = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    resultSrc = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    case (out_state)
      S_FETCH: begin
        ir_wr     = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      S_MEMREAD: adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc = 2'b01;
        reg_wr    = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc = 1'b1;
        mem_wr = 1'b1;
      end
      S_EXECR: begin
        aluSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_wr = 1'b1;
      S_BEQ: begin
        aluSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign irWrite  = ir_wr  & ~rst;
  assign regWrite = reg_wr & ~rst;
  assign memWrite = mem_wr & ~rst;
  assign pcWrite  = (pc_update | (branch & zero)) & ~rst;

  always_comb begin
    case (op)
      OP_SW:   immSrc = IMM_S;
      OP_BEQ:  immSrc = IMM_B;
      OP_JAL:  immSrc = IMM_J;
      default: immSrc = IMM_I;
    endcase
  end

  alu_dec u_alu_dec (
    .aluOp      (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .aluControl (aluControl)
  );

endmodule
